// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch FIFO of {pc, instr} entries with push, pop, synchronous flush and occupancy count.
// The head entry reads as zero when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count
);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  // Pointers and count; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail] <= wdata;
  end

  assign rdata = (count != '0) ? mem[head] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC, fetch queue to decode, redirect handling.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects into HALT instead of aligning them.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            misalign_err
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            push, pop, flush;
  logic [CW-1:0]   count;
  fetch_entry_t    head;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic err_d;
`endif

  assign pop = out_valid & out_ready;

  // Next state, next PC and queue control; a redirect overrides push and pop.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush   = 1'b0;
    push    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    err_d   = 1'b0;
`endif
    if (redirect_valid) begin
      flush = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        err_d   = 1'b1;
        state_d = HALT;
      end else begin
        state_d = RUN;
        pc_d    = redirect_pc;
      end
`else
      pc_d = redirect_pc & ~XLEN'(3);
`endif
    end else if (state_q == RUN && (count < CW'(QDEPTH) || pop)) begin
      push = 1'b1;
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign_err <= 1'b0;
    else      misalign_err <= err_d;
  end
`else
  assign misalign_err = 1'b0;
`endif

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .wdata('{pc: pc_q, instr: imem_rdata}),
    .rdata(head),
    .count(count)
  );

  assign imem_addr = pc_q;
  assign out_valid = (count != '0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: streaming, backpressure, redirect, trap, wrap and async reset.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready, misalign_err;
  logic [31:0] out_instr, out_pc;

  logic [31:0] w_addr, w_rdata, w_instr, w_pc;
  logic        w_valid, w_ready, w_err;
  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;

  int checks = 0;
  int errors = 0;
  fetch_entry_t exp_q[$];
  fetch_entry_t exp2_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'h0013} ^ 32'h5A5A_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign w_rdata    = mem_word(w_addr);

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .misalign_err(misalign_err)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(4)) u_wrap (
    .clk(clk), .rst(rst), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
    .out_valid(w_valid), .out_ready(w_ready), .out_instr(w_instr),
    .out_pc(w_pc), .misalign_err(w_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back('{pc: pc, instr: mem_word(pc)});
  endtask

  // Monitors: compare every accepted head entry against the expected stream.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL main_accept: unexpected pc=%h instr=%h", out_pc, out_instr);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          errors++;
          $display("FAIL main_accept: got pc=%h instr=%h expected pc=%h instr=%h",
                   out_pc, out_instr, e.pc, e.instr);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && w_valid && w_ready) begin
      checks++;
      if (exp2_q.size() == 0) begin
        errors++;
        $display("FAIL wrap_accept: unexpected pc=%h instr=%h", w_pc, w_instr);
      end else begin
        fetch_entry_t e;
        e = exp2_q.pop_front();
        if (w_pc !== e.pc || w_instr !== e.instr) begin
          errors++;
          $display("FAIL wrap_accept: got pc=%h instr=%h expected pc=%h instr=%h",
                   w_pc, w_instr, e.pc, e.instr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    out_ready = 1'b0;
    w_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    tick(2);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_err", 32'(misalign_err), 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);

    // Streaming on both instances; wrap instance crosses 2^32.
    rst = 1'b1;
    out_ready = 1'b1;
    w_ready = 1'b1;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    exp2_q.push_back('{pc: 32'hFFFF_FFF8, instr: mem_word(32'hFFFF_FFF8)});
    exp2_q.push_back('{pc: 32'hFFFF_FFFC, instr: mem_word(32'hFFFF_FFFC)});
    exp2_q.push_back('{pc: 32'h0000_0000, instr: mem_word(32'h0000_0000)});
    tick(4);
    out_ready = 1'b0;
    w_ready = 1'b0;
    check("stream_head", out_pc, 32'hC);
    check("stream_drained", 32'(exp_q.size()), 32'h0);
    check("wrap_drained", 32'(exp2_q.size()), 32'h0);

    // Asynchronous reset between edges.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'h0);
    check("async_pc", out_pc, 32'h0);
    check("async_addr", imem_addr, 32'h0);

    // Backpressure from reset: fills to QDEPTH=2, head held.
    tick(1);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_head", out_pc, 32'h0);
    end
    check("bp_pc_stop", imem_addr, 32'h8);
    out_ready = 1'b1;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    tick(4);
    out_ready = 1'b0;
    check("bp_drained", 32'(exp_q.size()), 32'h0);

    // Redirect with a full queue.
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick(1);
    redirect_valid = 1'b0;
    check("redir_flush", 32'(out_valid), 32'h0);
    out_ready = 1'b1;
    expect_pc(32'h100); expect_pc(32'h104);
    tick(1);
    check("redir_valid", 32'(out_valid), 32'h1);
    check("redir_head", out_pc, 32'h100);
    tick(2);
    out_ready = 1'b0;
    check("redir_drained", 32'(exp_q.size()), 32'h0);

    // Misaligned redirect.
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    tick(1);
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    check("trap_err", 32'(misalign_err), 32'h1);
    check("trap_flush", 32'(out_valid), 32'h0);
    out_ready = 1'b1;
    tick(1);
    check("trap_err_pulse", 32'(misalign_err), 32'h0);
    check("halt_valid", 32'(out_valid), 32'h0);
    check("halt_pc", imem_addr, 32'h10C);
    redirect_valid = 1'b1;
    redirect_pc = 32'h206;
    tick(1);
    redirect_valid = 1'b0;
    check("halt_err_again", 32'(misalign_err), 32'h1);
    check("halt_valid2", 32'(out_valid), 32'h0);
    tick(1);
    check("halt_err_clear", 32'(misalign_err), 32'h0);
    check("halt_valid3", 32'(out_valid), 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick(1);
    redirect_valid = 1'b0;
    check("resume_pc", imem_addr, 32'h200);
    expect_pc(32'h200); expect_pc(32'h204);
    tick(3);
    out_ready = 1'b0;
`else
    check("align_err", 32'(misalign_err), 32'h0);
    check("align_flush", 32'(out_valid), 32'h0);
    check("align_pc", imem_addr, 32'h100);
    out_ready = 1'b1;
    expect_pc(32'h100); expect_pc(32'h104);
    tick(3);
    out_ready = 1'b0;
    check("align_err_after", 32'(misalign_err), 32'h0);
`endif
    tick(2);
    check("final_drained", 32'(exp_q.size()), 32'h0);
    check("final_wrap_drained", 32'(exp2_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter QDEPTH, default 2, meaning the fetch-queue depth; legal values are 2, 4 and 8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port imem_addr, output, 32 bits: the instruction-memory byte address, equal to the current PC.
REQ-006 SHALL have port imem_rdata, input, 32 bits: the instruction word, returned combinationally in the same cycle.
REQ-007 SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-008 SHALL have port redirect_pc, input, 32 bits: the redirect target address.
REQ-009 SHALL have port out_valid, output, 1 bit: the head queue entry is valid to decode.
REQ-010 SHALL have port out_ready, input, 1 bit: decode accepts the head entry.
REQ-011 SHALL have port out_instr, output, 32 bits: the head instruction word.
REQ-012 SHALL have port out_pc, output, 32 bits: the head instruction address.
REQ-013 SHALL have port misalign_err, output, 1 bit: the misaligned-redirect error pulse.

Function
REQ-014 SHALL drive imem_addr = PC combinationally; imem_rdata is sampled in the same cycle.
REQ-015 SHALL define pop = out_valid & out_ready.
REQ-016 SHALL define push = state RUN & ~redirect_valid & (count < QDEPTH | pop); a push writes {PC, imem_rdata} to the queue tail and sets PC <= PC+4.
REQ-017 SHALL wrap the PC modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0.
REQ-018 SHALL allow a simultaneous push and pop when the queue is full; count is then unchanged.
REQ-019 SHALL drive out_valid = (count != 0) and present out_instr/out_pc from the head; both SHALL be 0 when the queue is empty.
REQ-020 SHALL hold out_valid, out_instr and out_pc stable while out_valid & ~out_ready.
REQ-021 SHALL, on redirect_valid: flush the queue (count <= 0), set PC <= target, and perform no push; redirect SHALL override push and pop in that cycle.
REQ-022 SHALL give a latency of one cycle: an instruction fetched at edge N is presented with out_valid high after edge N.
REQ-023 SHALL implement a state machine with states RUN and HALT; RUN is the reset state; HALT is reachable only when FETCH_MISALIGN_TRAP_EN is defined (REQ-029).
REQ-024 SHALL keep the head and tail pointers at log2(QDEPTH) bits, wrapping naturally, with a count field of log2(QDEPTH)+1 bits.

Reset
REQ-025 SHALL, while rst=0 (asynchronously): set PC = RESET_PC, count = 0, pointers = 0, state = RUN, and drive out_valid = 0, out_instr = 0, out_pc = 0, misalign_err = 0.
REQ-026 SHALL, on assertion of reset mid-operation, discard all queued entries immediately; after release, the first push occurs at the first clk edge.

Configuration
REQ-027 SHALL use the macro FETCH_MISALIGN_TRAP_EN to enable the misaligned-redirect trap.
REQ-028 SHALL, when FETCH_MISALIGN_TRAP_EN is undefined: force redirect_pc[1:0] to 00 before loading the PC and tie misalign_err to 0.
REQ-029 SHALL, when FETCH_MISALIGN_TRAP_EN is defined and redirect_valid & redirect_pc[1:0] != 0: flush the queue, assert misalign_err registered for exactly one cycle, and enter HALT with the PC unchanged.
REQ-030 SHALL, in HALT: perform no pushes; an aligned redirect SHALL return to RUN with PC <= target; a misaligned redirect SHALL stay in HALT and pulse misalign_err again.

Structure
REQ-031 SHALL place in package fetch_pkg: the XLEN=32 constant, the RESET_PC default, the fetch_entry_t struct {pc, instr}, and the state enum {RUN, HALT}.
REQ-032 SHALL implement the queue as sub-module fetch_queue (parameterised FIFO with push, pop, flush and count), instantiated once.

Verification
REQ-033 SHALL verify streaming: release reset, hold out_ready=1 -> out_pc = 0x0, 0x4, 0x8 on consecutive cycles, with out_instr equal to memory words 0, 1, 2.
REQ-034 SHALL verify backpressure: out_ready=0 for 5 cycles -> count saturates at QDEPTH, PC stops at 4*QDEPTH, and the head is held stable; ready=1 -> in-order drain with no loss.
REQ-035 SHALL verify redirect: redirect_pc=0x100 with a full queue -> out_valid=0 in the next cycle, then out_pc=0x100 one cycle later.
REQ-036 SHALL verify wrap: RESET_PC=32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 SHALL verify the trap (with macro): redirect_pc=0x102 -> misalign_err high for one cycle, no further out_valid; then redirect 0x200 -> fetch resumes at 0x200. Without the macro: the same stimulus -> fetch at 0x100 and misalign_err=0.
REQ-038 SHALL verify asynchronous reset: assert rst=0 mid-stream between edges -> out_valid falls immediately; after release, out_pc restarts at RESET_PC.
